// File: rtl/ps2_letter_decoder_if.sv
// PS/2 letter decoder bus: raw keyboard lines in,
// released-letter events and frame errors out.
interface ps2_letter_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [4:0] keystroke;
  logic       keyReleased;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  keystroke,
    input  keyReleased,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output keystroke,
    output keyReleased,
    output frame_err
  );
endinterface

// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 receiver that turns letter key releases
// into 5-bit codes (A=1 .. Z=26) for the word checker.
module ps2_letter_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input logic clk,
  input logic rst_n,
  ps2_letter_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE, EXT, BRK, EXT_BRK
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_last;
  logic                   fall;
  logic                   bit_in;

  logic [3:0]    bit_cnt;
  logic [9:0]    sr;
  logic [TW-1:0] tmo;
  logic [10:0]   frame;
  logic          frame_ok;
  logic          byte_valid;
  logic          err;
  logic [7:0]    rx_byte;

  state_t     state;
  state_t     state_n;
  logic [4:0] code;
  logic       hit;
  logic [4:0] ks;
  logic       rel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_last  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
      clk_last  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_last & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  // sr holds bits 0..9 with the start bit at sr[0]
  assign frame    = {bit_in, sr};
  assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      sr         <= '0;
      tmo        <= '0;
      byte_valid <= 1'b0;
      err        <= 1'b0;
      rx_byte    <= '0;
    end else begin
      byte_valid <= 1'b0;
      err        <= 1'b0;
      if (fall) begin
        tmo <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt    <= '0;
          byte_valid <= frame_ok;
          err        <= !frame_ok;
          rx_byte    <= frame[8:1];
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          sr      <= {bit_in, sr[9:1]};
        end
      end else if (bit_cnt == 4'd0) begin
        tmo <= '0;
      end else if (tmo == TMAX) begin
        bit_cnt <= '0;
        tmo     <= '0;
      end else begin
        tmo <= tmo + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (byte_valid) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            (rx_byte == 8'hE0): state_n = EXT;
            (rx_byte == 8'hF0): state_n = BRK;
            default:            state_n = IDLE;
          endcase
        end
        EXT:     state_n = (rx_byte == 8'hF0) ? EXT_BRK : IDLE;
        BRK:     state_n = IDLE;
        EXT_BRK: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    code = 5'd0;
    unique case (rx_byte)
      8'h1C:   code = 5'd1;
      8'h32:   code = 5'd2;
      8'h21:   code = 5'd3;
      8'h23:   code = 5'd4;
      8'h24:   code = 5'd5;
      8'h2B:   code = 5'd6;
      8'h34:   code = 5'd7;
      8'h33:   code = 5'd8;
      8'h43:   code = 5'd9;
      8'h3B:   code = 5'd10;
      8'h42:   code = 5'd11;
      8'h4B:   code = 5'd12;
      8'h3A:   code = 5'd13;
      8'h31:   code = 5'd14;
      8'h44:   code = 5'd15;
      8'h4D:   code = 5'd16;
      8'h15:   code = 5'd17;
      8'h2D:   code = 5'd18;
      8'h1B:   code = 5'd19;
      8'h2C:   code = 5'd20;
      8'h3C:   code = 5'd21;
      8'h2A:   code = 5'd22;
      8'h1D:   code = 5'd23;
      8'h22:   code = 5'd24;
      8'h35:   code = 5'd25;
      8'h1A:   code = 5'd26;
      default: code = 5'd0;
    endcase
    hit = byte_valid && (state == BRK) && (code != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ks  <= '0;
      rel <= 1'b0;
    end else begin
      rel <= hit;
      if (hit) ks <= code;
    end
  end

  assign bus.keystroke   = ks;
  assign bus.keyReleased = rel;
  assign bus.frame_err   = err;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Scoreboard bench for ps2_letter_decoder: expected
// release codes are queued as frames are sent.
module tb_ps2_letter_decoder;

  localparam int TMO = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ps2_letter_decoder_if bus();

  ps2_letter_decoder #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rel_cnt  = 0;
  int err_cnt  = 0;
  int hi_t     = 3;
  int lo_t     = 6;

  logic [4:0] exp_q[$];
  logic [4:0] exp_code;
  logic       rel_prev = 1'b0;
  logic       err_prev = 1'b0;
  logic [4:0] ks_prev  = 5'd0;

  logic [7:0] letters [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  // Release monitor: pops the scoreboard on every pulse
  always @(negedge clk) begin
    if (bus.keyReleased === 1'b1) begin
      rel_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_release: keystroke=%0d, none expected",
                 bus.keystroke);
      end else begin
        exp_code = exp_q.pop_front();
        if (bus.keystroke !== exp_code) begin
          n_fail++;
          $display("FAIL release_code: got %0d, want %0d",
                   bus.keystroke, exp_code);
        end
      end
    end
    if (rel_prev) begin
      n_checks++;
      if (bus.keyReleased !== 1'b0 || bus.keystroke !== ks_prev) begin
        n_fail++;
        $display("FAIL release_width: rel=%b ks=%0d, want rel=0 ks=%0d",
                 bus.keyReleased, bus.keystroke, ks_prev);
      end
    end
    if (bus.frame_err === 1'b1) err_cnt++;
    if (err_prev) begin
      n_checks++;
      if (bus.frame_err !== 1'b0) begin
        n_fail++;
        $display("FAIL err_width: frame_err=%b, want 0", bus.frame_err);
      end
    end
    rel_prev = bus.keyReleased;
    err_prev = bus.frame_err;
    ks_prev  = bus.keystroke;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_of(
    input logic [7:0] b,
    input logic bad_par,
    input logic bad_start,
    input logic bad_stop
  );
    return {~bad_stop, (~^b) ^ bad_par, b, bad_start};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = f[i];
      wait_clk(hi_t);
      bus.ps2_clk = 1'b0;
      wait_clk(lo_t);
      bus.ps2_clk = 1'b1;
      wait_clk(hi_t);
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame_of(b, 1'b0, 1'b0, 1'b0), 11);
    wait_clk(4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clk(3);
    n_checks++;
    if (bus.keystroke !== 5'd0 || bus.keyReleased !== 1'b0
        || bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ks=%0d rel=%b err=%b, want 0 0 0",
               bus.keystroke, bus.keyReleased, bus.frame_err);
    end
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_make_break;
    int r0 = rel_cnt;
    send_byte(8'h1C);
    wait_clk(10);
    n_checks++;
    if (rel_cnt != r0) begin
      n_fail++;
      $display("FAIL make_no_pulse: got %0d pulses, want 0", rel_cnt - r0);
    end
    send_byte(8'hF0);
    exp_q.push_back(5'd1);
    send_byte(8'h1C);
    wait_clk(20);
    n_checks++;
    if (rel_cnt - r0 != 1 || bus.keystroke !== 5'd1) begin
      n_fail++;
      $display("FAIL make_break: pulses=%0d ks=%0d, want 1 1",
               rel_cnt - r0, bus.keystroke);
    end
  endtask

  task automatic test_typematic;
    int r0 = rel_cnt;
    repeat (3) send_byte(8'h1A);
    send_byte(8'hF0);
    exp_q.push_back(5'd26);
    send_byte(8'h1A);
    wait_clk(20);
    n_checks++;
    if (rel_cnt - r0 != 1 || bus.keystroke !== 5'd26) begin
      n_fail++;
      $display("FAIL typematic_z: pulses=%0d ks=%0d, want 1 26",
               rel_cnt - r0, bus.keystroke);
    end
    send_byte(8'hF0);
    exp_q.push_back(5'd17);
    send_byte(8'h15);
    wait_clk(20);
    n_checks++;
    if (rel_cnt - r0 != 2 || bus.keystroke !== 5'd17) begin
      n_fail++;
      $display("FAIL typematic_q: pulses=%0d ks=%0d, want 2 17",
               rel_cnt - r0, bus.keystroke);
    end
  endtask

  task automatic test_frame_errors;
    int r0 = rel_cnt;
    int e0 = err_cnt;
    send_byte(8'hF0);
    send_bits(frame_of(8'h1C, 1'b1, 1'b0, 1'b0), 11);
    wait_clk(10);
    n_checks++;
    if (err_cnt - e0 != 1 || rel_cnt != r0) begin
      n_fail++;
      $display("FAIL parity_err: errs=%0d pulses=%0d, want 1 0",
               err_cnt - e0, rel_cnt - r0);
    end
    send_bits(frame_of(8'h1C, 1'b0, 1'b0, 1'b1), 11);
    wait_clk(10);
    send_bits(frame_of(8'h1C, 1'b0, 1'b1, 1'b0), 11);
    wait_clk(10);
    n_checks++;
    if (err_cnt - e0 != 3 || rel_cnt != r0 || bus.keystroke !== 5'd17) begin
      n_fail++;
      $display("FAIL stop_start_err: errs=%0d pulses=%0d ks=%0d, want 3 0 17",
               err_cnt - e0, rel_cnt - r0, bus.keystroke);
    end
    exp_q.push_back(5'd1);
    send_byte(8'h1C);
    wait_clk(20);
    n_checks++;
    if (rel_cnt - r0 != 1 || bus.keystroke !== 5'd1) begin
      n_fail++;
      $display("FAIL err_recover: pulses=%0d ks=%0d, want 1 1",
               rel_cnt - r0, bus.keystroke);
    end
  endtask

  task automatic test_extended;
    int r0 = rel_cnt;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h29);
    send_byte(8'hF0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    wait_clk(20);
    n_checks++;
    if (rel_cnt != r0 || bus.keystroke !== 5'd1) begin
      n_fail++;
      $display("FAIL extended_ignored: pulses=%0d ks=%0d, want 0 1",
               rel_cnt - r0, bus.keystroke);
    end
    send_byte(8'hE0);
    send_byte(8'h1A);
    send_byte(8'hF0);
    exp_q.push_back(5'd26);
    send_byte(8'h1A);
    wait_clk(20);
    n_checks++;
    if (rel_cnt - r0 != 1 || bus.keystroke !== 5'd26) begin
      n_fail++;
      $display("FAIL ext_then_letter: pulses=%0d ks=%0d, want 1 26",
               rel_cnt - r0, bus.keystroke);
    end
  endtask

  task automatic test_timeout;
    int r0 = rel_cnt;
    int e0 = err_cnt;
    send_bits(frame_of(8'h1C, 1'b0, 1'b0, 1'b0), 5);
    wait_clk(TMO + 1);
    send_byte(8'hF0);
    exp_q.push_back(5'd5);
    send_byte(8'h24);
    wait_clk(20);
    n_checks++;
    if (rel_cnt - r0 != 1 || err_cnt != e0 || bus.keystroke !== 5'd5) begin
      n_fail++;
      $display("FAIL timeout: pulses=%0d errs=%0d ks=%0d, want 1 0 5",
               rel_cnt - r0, err_cnt - e0, bus.keystroke);
    end
  endtask

  task automatic test_reset_mid;
    int r0;
    int e0;
    send_byte(8'hF0);
    send_bits(frame_of(8'h1C, 1'b0, 1'b0, 1'b0), 4);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    n_checks++;
    if (bus.keystroke !== 5'd0 || bus.keyReleased !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: ks=%0d rel=%b, want 0 0",
               bus.keystroke, bus.keyReleased);
    end
    r0 = rel_cnt;
    e0 = err_cnt;
    wait_clk(10);
    send_byte(8'h1C);
    wait_clk(20);
    n_checks++;
    if (rel_cnt != r0 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL prefix_cleared: pulses=%0d errs=%0d, want 0 0",
               rel_cnt - r0, err_cnt - e0);
    end
    send_byte(8'hF0);
    exp_q.push_back(5'd1);
    send_byte(8'h1C);
    wait_clk(20);
    n_checks++;
    if (rel_cnt - r0 != 1 || bus.keystroke !== 5'd1) begin
      n_fail++;
      $display("FAIL after_reset: pulses=%0d ks=%0d, want 1 1",
               rel_cnt - r0, bus.keystroke);
    end
  endtask

  task automatic test_all_letters;
    int r0 = rel_cnt;
    int e0 = err_cnt;
    for (int i = 0; i < 26; i++) begin
      send_byte(8'hF0);
      exp_q.push_back(5'(i + 1));
      send_byte(letters[i]);
    end
    wait_clk(20);
    n_checks++;
    if (rel_cnt - r0 != 26 || err_cnt != e0 || bus.keystroke !== 5'd26) begin
      n_fail++;
      $display("FAIL all_letters: pulses=%0d errs=%0d ks=%0d, want 26 0 26",
               rel_cnt - r0, err_cnt - e0, bus.keystroke);
    end
  endtask

  task automatic test_back_to_back;
    int r0 = rel_cnt;
    hi_t = 2;
    lo_t = 4;
    send_bits(frame_of(8'hF0, 1'b0, 1'b0, 1'b0), 11);
    exp_q.push_back(5'd2);
    send_bits(frame_of(8'h32, 1'b0, 1'b0, 1'b0), 11);
    send_bits(frame_of(8'hF0, 1'b0, 1'b0, 1'b0), 11);
    exp_q.push_back(5'd3);
    send_bits(frame_of(8'h21, 1'b0, 1'b0, 1'b0), 11);
    hi_t = 3;
    lo_t = 6;
    wait_clk(20);
    n_checks++;
    if (rel_cnt - r0 != 2 || bus.keystroke !== 5'd3) begin
      n_fail++;
      $display("FAIL back_to_back: pulses=%0d ks=%0d, want 2 3",
               rel_cnt - r0, bus.keystroke);
    end
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    test_reset();
    test_make_break();
    test_typematic();
    test_frame_errors();
    test_extended();
    test_timeout();
    test_reset_mid();
    test_all_letters();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_release: %0d expected pulses never seen, want 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_letter_decoder.md
Name: ps2_letter_decoder

Overview:
- Front end of the typing game.
- Receives raw PS/2 keyboard frames, tracks make/break/extended prefixes, and translates set-2 scancodes for A–Z into the 5-bit letter code consumed by the word-checking stage.
- Emits one release event per letter key; that event drives the checker's keystroke/keyReleased inputs directly.

Parameters:
- TIMEOUT_CYCLES, 100000, clk cycles with no PS/2 falling edge before a partial frame is discarded (1 ms at 100 MHz).
- SYNC_STAGES, 2, synchronizer depth on ps2_clk and ps2_data (min 2).

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst_n  input  1  synchronous, active-low reset.
- ps2_clk  input  1  raw keyboard clock, asynchronous.
- ps2_data  input  1  raw keyboard data, asynchronous.
- keystroke  output  5  letter code of the last released key: A=1 … Z=26; 0 = none since reset.
- keyReleased  output  1  one-cycle high pulse when keystroke is updated.
- frame_err  output  1  one-cycle pulse on parity, start-bit or stop-bit error.

Behaviour:
- Reset (rst_n=0 at posedge clk) clears the following to 0: keystroke, keyReleased, frame_err, bit counter, shift register, timeout counter and prefix state. Synchronizer flops reset to 1 (idle bus).
- ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is the synced clock going 1→0 between consecutive clk cycles. Data is sampled on that same cycle.
- Frame: 11 bits. Start bit = 0, then 8 data bits LSB first, odd parity, stop bit = 1. A bit counter of 0..10 increments on each falling edge.
- On the 11th bit, check start=0, stop=1 and odd parity over data+parity:
  - Any failure: pulse frame_err for 1 cycle, discard the byte, prefix state unchanged.
  - All pass: byte_valid is asserted internally for 1 cycle.
- Timeout: the counter runs while the bit counter ≠ 0. It resets on each falling edge. When it reaches TIMEOUT_CYCLES, the bit counter returns to 0 and frame_err is not asserted. It is idle while the bit counter is 0.
- Prefix FSM, advanced only on byte_valid:
  - IDLE: E0→EXT; F0→BREAK; any other byte is a make/typematic repeat → ignored, stay IDLE.
  - EXT: F0→EXT_BREAK; other→IDLE (extended make ignored).
  - BREAK: any byte → lookup, then IDLE.
  - EXT_BREAK: any byte → IDLE, no output (extended keys are never letters).
- Lookup, set-2 scancode → code:
  - 1C=1, 32=2, 21=3, 23=4, 24=5, 2B=6, 34=7, 33=8, 43=9, 3B=10, 42=11, 4B=12, 3A=13
  - 31=14, 44=15, 4D=16, 15=17, 2D=18, 1B=19, 2C=20, 3C=21, 2A=22, 1D=23, 22=24, 35=25, 1A=26
  - Any other byte → no output.
- Output timing: on a letter hit, keystroke is registered on the cycle after byte_valid, and keyReleased is high on that same cycle only. keystroke holds until the next letter hit, so it is stable before and after the keyReleased rising edge.
- F0 received while in BREAK is treated as the scancode (not a letter) → IDLE.
- rst_n low mid-frame: partial frame dropped; the next frame is decoded normally, starting from its start bit.
- Minimum PS/2 bit period is ≥ 8 clk cycles; faster input is undefined.

Test Plan:
- Frames 1C, F0, 1C → keyReleased pulses once, exactly 1 cycle, after the second 1C; keystroke=1; no pulse after the make code.
- Frames 1A ×3 (typematic), F0, 1A → one pulse, keystroke=26; then F0, 15 → second pulse, keystroke=17.
- Frame F0 followed by 0x1C with even parity → frame_err 1-cycle pulse, no keyReleased, FSM stays BREAK. Next valid 1C → keystroke=1 pulse.
- Frames E0, F0, 1C (extended) → no keyReleased, keystroke unchanged. Frames F0, 29 (space) → no keyReleased.
- Send 5 bits of a frame, idle TIMEOUT_CYCLES+1 clk, then full frames F0, 24 → keystroke=5 pulse, frame_err never asserted.
- Assert rst_n=0 for 1 cycle mid-frame after F0 received → keystroke=0, keyReleased=0. Then 1C alone → no pulse (prefix cleared). Then F0, 1C → pulse, keystroke=1.
